// File: rtl/decompress_unit.sv
// Two-code run-length decoder: expands {value,length} byte pairs into a 256-bit MSB-first buffer.
// Optional build macro DECOMP_PAD_LAST_EN fills the unused tail with the last decoded bit.
module decompress_unit (
    input  logic         clk,
    input  logic         RST,
    input  logic [7:0]   in1,
    input  logic [7:0]   in2,
    input  logic         work,
    output logic [255:0] out,
    output logic [31:0]  byteIndx,
    output logic [2:0]   bitIndx,
    output logic         done
);

    // state | meaning
    // IDLE  | waiting for first work after reset
    // RUN1  | writing first run at the top of the buffer
    // RUN2  | writing second run after the first, computing indices
    // FIN   | raising done
    // DONE  | results held; work starts a new decode
    typedef enum logic [2:0] {IDLE, RUN1, RUN2, FIN, DONE} state_t;

    localparam logic [255:0] ALL_ONES = '1;

    state_t      state;
    logic [7:0]  code1;
    logic [7:0]  code2;
    logic [7:0]  ptr;

    logic [7:0]   total;
    logic [8:0]   shift1;
    logic [8:0]   shiftPtr;
    logic [8:0]   shiftTotal;
    logic [255:0] run1Mask;
    logic [255:0] headMask;
    logic [255:0] usedMask;
    logic [255:0] run2Mask;
    logic [255:0] tailMask;
    logic         padBit;

    assign total      = {1'b0, code1[6:0]} + {1'b0, code2[6:0]};
    assign shift1     = {2'b00, code1[6:0]};
    assign shiftPtr   = {1'b0, ptr};
    assign shiftTotal = {1'b0, total};

    // A mask of the top N bits is the complement of all-ones shifted right by N.
    assign run1Mask = ~(ALL_ONES >> shift1);
    assign headMask = ~(ALL_ONES >> shiftPtr);
    assign usedMask = ~(ALL_ONES >> shiftTotal);
    assign run2Mask = usedMask & ~headMask;
    assign tailMask = ALL_ONES >> shiftTotal;

`ifdef DECOMP_PAD_LAST_EN
    assign padBit = (code2[6:0] != 7'd0) ? code2[7] :
                    (code1[6:0] != 7'd0) ? code1[7] : 1'b0;
`else
    assign padBit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= IDLE;
            code1    <= '0;
            code2    <= '0;
            ptr      <= '0;
            out      <= '0;
            byteIndx <= '0;
            bitIndx  <= 3'd7;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (work) begin
                        code1 <= in1;
                        code2 <= in2;
                        done  <= 1'b0;
                        out   <= '0;
                        state <= RUN1;
                    end
                end
                RUN1: begin
                    out   <= code1[7] ? (out | run1Mask) : (out & ~run1Mask);
                    ptr   <= {1'b0, code1[6:0]};
                    state <= RUN2;
                end
                RUN2: begin
                    out      <= (code2[7] ? (out | run2Mask) : (out & ~run2Mask))
                                | ({256{padBit}} & tailMask);
                    byteIndx <= {27'd0, total[7:3]};
                    bitIndx  <= ~total[2:0];
                    state    <= FIN;
                end
                FIN: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decompress_unit.sv
// Scoreboard bench for decompress_unit: directed code pairs with hand-computed buffers and indices.
// Honours DECOMP_PAD_LAST_EN when choosing the expected tail contents.
module tb_decompress_unit;

    logic         clk;
    logic         RST;
    logic [7:0]   in1;
    logic [7:0]   in2;
    logic         work;
    logic [255:0] out;
    logic [31:0]  byteIndx;
    logic [2:0]   bitIndx;
    logic         done;

    decompress_unit dut (
        .clk(clk), .RST(RST), .in1(in1), .in2(in2), .work(work),
        .out(out), .byteIndx(byteIndx), .bitIndx(bitIndx), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [255:0] out;
        logic [31:0]  byteIdx;
        logic [2:0]   bitIdx;
    } exp_t;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic prevDone = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: every rising edge of done consumes one expectation.
    always @(negedge clk) begin
        if (RST) begin
            prevDone = 1'b0;
        end else begin
            if (done && !prevDone) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1 want no result pending");
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check({e.name, "_out"}, out, e.out);
                    check({e.name, "_byteIndx"}, {224'd0, byteIndx}, {224'd0, e.byteIdx});
                    check({e.name, "_bitIndx"}, {253'd0, bitIndx}, {253'd0, e.bitIdx});
                end
            end
            prevDone = done;
        end
    end

    // Waits after the accepting edge; done must first appear 3 edges later.
    task automatic waitDone(input string name);
        int cycles;
        cycles = 0;
        while (!done && cycles < 10) begin
            @(posedge clk); #1;
            cycles++;
        end
        check({name, "_latency"}, 256'(cycles), 256'd3);
    endtask

    task automatic runVector(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [255:0] eOut, input logic [31:0] eByte, input logic [2:0] eBit);
        exp_t e;
        e.name = name; e.out = eOut; e.byteIdx = eByte; e.bitIdx = eBit;
        expQ.push_back(e);
        in1 = a; in2 = b; work = 1'b1;
        @(posedge clk); #1;
        work = 1'b0;
        in1 = 8'h55; in2 = 8'hAA;
        waitDone(name);
        @(posedge clk); #1;
    endtask

    logic [255:0] e255;

    initial begin
        RST = 1'b1; work = 1'b0; in1 = '0; in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", out, '0);
        check("reset_done", {255'd0, done}, 256'd0);
        check("reset_byteIndx", {224'd0, byteIndx}, 256'd0);
        check("reset_bitIndx", {253'd0, bitIndx}, 256'd7);
        RST = 1'b0;
        @(posedge clk); #1;

        runVector("v83_05", 8'h83, 8'h05, {8'hE0, 248'd0}, 32'd1, 3'd7);

`ifdef DECOMP_PAD_LAST_EN
        e255 = '1;
`else
        e255 = {{254{1'b1}}, 2'b00};
`endif
        runVector("vFF_FF", 8'hFF, 8'hFF, e255, 32'd31, 3'd1);

`ifdef DECOMP_PAD_LAST_EN
        e255 = '1;
`else
        e255 = {{10{1'b1}}, 246'd0};
`endif
        runVector("v00_8A", 8'h00, 8'h8A, e255, 32'd1, 3'd5);

`ifdef DECOMP_PAD_LAST_EN
        e255 = {3'b000, {253{1'b1}}};
`else
        e255 = {3'b000, 5'b11111, 248'd0};
`endif
        runVector("v03_85", 8'h03, 8'h85, e255, 32'd1, 3'd7);

        runVector("v80_00", 8'h80, 8'h00, '0, 32'd0, 3'd7);

`ifdef DECOMP_PAD_LAST_EN
        e255 = '1;
`else
        e255 = {1'b1, 255'd0};
`endif
        runVector("v81_00", 8'h81, 8'h00, e255, 32'd0, 3'd6);

`ifdef DECOMP_PAD_LAST_EN
        e255 = {127'd0, {129{1'b1}}};
`else
        e255 = {127'd0, 1'b1, 128'd0};
`endif
        runVector("v7F_81", 8'h7F, 8'h81, e255, 32'd16, 3'd7);

        // Reset arriving while the decoder is in RUN2 wipes everything.
        in1 = 8'hFF; in2 = 8'hFF; work = 1'b1;
        @(posedge clk); #1;
        work = 1'b0;
        @(posedge clk); #1;
        RST = 1'b1;
        @(posedge clk); #1;
        RST = 1'b0;
        check("midreset_out", out, '0);
        check("midreset_done", {255'd0, done}, 256'd0);
        check("midreset_byteIndx", {224'd0, byteIndx}, 256'd0);
        check("midreset_bitIndx", {253'd0, bitIndx}, 256'd7);
        repeat (6) @(posedge clk);
        #1;
        check("midreset_no_done", {255'd0, done}, 256'd0);

        // A second request during RUN1 with different codes must be ignored.
        begin
            exp_t e;
            e.name = "ignore_run1"; e.out = {8'hE0, 248'd0}; e.byteIdx = 32'd1; e.bitIdx = 3'd7;
            expQ.push_back(e);
        end
        in1 = 8'h83; in2 = 8'h05; work = 1'b1;
        @(posedge clk); #1;
        in1 = 8'hFF; in2 = 8'hFF;
        @(posedge clk); #1;
        work = 1'b0;
        begin
            int cycles;
            cycles = 1;
            while (!done && cycles < 10) begin
                @(posedge clk); #1;
                cycles++;
            end
            check("ignore_run1_latency", 256'(cycles), 256'd3);
        end
        repeat (8) @(posedge clk);
        #1;
        check("ignore_run1_done_held", {255'd0, done}, 256'd1);
        check("ignore_run1_out_stable", out, {8'hE0, 248'd0});

        check("scoreboard_empty", 256'(expQ.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
